// File: rtl/ternary_issue_scoreboard.sv
// Dual-issue ID-stage controller for the ternary pipeline: tracks outstanding
// loads (pending mask + in-order completion FIFO) and decides Slot A / Slot B issue.
package ternary_issue_scoreboard_pkg;
   typedef logic [1:0] trit_t;
   localparam trit_t T_ZERO = 2'b00;
   localparam trit_t T_POS  = 2'b01;
   localparam trit_t T_NEG  = 2'b10;
endpackage

module ternary_issue_scoreboard
   import ternary_issue_scoreboard_pkg::*;
#(
   parameter int NUM_REGS    = 27,
   parameter int MAX_PENDING = 4,
   parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid_a,
   input  logic              id_valid_b,
   input  trit_t [2:0]       id_rs1_a,
   input  trit_t [2:0]       id_rs2_a,
   input  trit_t [2:0]       id_rd_a,
   input  trit_t [2:0]       id_rs1_b,
   input  trit_t [2:0]       id_rs2_b,
   input  trit_t [2:0]       id_rd_b,
   input  logic              id_uses_rs1_a,
   input  logic              id_uses_rs2_a,
   input  logic              id_uses_rs1_b,
   input  logic              id_uses_rs2_b,
   input  logic              id_reg_write_a,
   input  logic              id_reg_write_b,
   input  logic              id_mem_read_a,
   input  logic              id_mem_read_b,
   input  logic              id_mem_write_a,
   input  logic              id_mem_write_b,
   input  logic              issue_flush,
   input  logic              mem_resp_valid,
   output logic              issue_a,
   output logic              issue_b,
   output logic              stall_a,
   output logic              b_hold,
   output trit_t [2:0]       resp_rd,
   output logic [CNT_W-1:0]  pending_count,
   output logic              fifo_full,
   output logic              resp_err
);

   localparam int PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int IDX_OF = (NUM_REGS - 1) / 2;

   logic [NUM_REGS-1:0] r_pending;
   trit_t [2:0]         r_fifo [MAX_PENDING];
   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [CNT_W-1:0]    r_count;
   logic                r_resp_err;

   logic                w_pop;
   logic                w_full;
   trit_t [2:0]         w_head_rd;
   logic                w_blk_rs1_a, w_blk_rs2_a, w_blk_rd_a;
   logic                w_blk_rs1_b, w_blk_rs2_b, w_blk_rd_b;
   logic                w_can_a, w_can_b;
   logic                w_raw, w_waw, w_mem_pair;
   logic                w_push_a, w_push_b, w_push;
   trit_t [2:0]         w_push_rd;
   logic [NUM_REGS-1:0] w_set, w_clr;

   // Balanced 3-trit value offset so that -13..+13 lands on 0..26.
   function automatic logic [IDX_W-1:0] f_idx(input trit_t [2:0] r);
      int v;
      int w;
      v = IDX_OF;
      w = 1;
      for (int i = 0; i < 3; i++) begin
         if (r[i] == T_POS) v = v + w;
         else if (r[i] == T_NEG) v = v - w;
         w = w * 3;
      end
      return v[IDX_W-1:0];
   endfunction

   function automatic logic f_is_r0(input trit_t [2:0] r);
      return r == {T_ZERO, T_ZERO, T_ZERO};
   endfunction

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // A register being written back by this cycle's response is already usable.
   function automatic logic f_blocked(input trit_t [2:0] r);
      return !f_is_r0(r) && r_pending[f_idx(r)] && !(w_pop && (w_head_rd == r));
   endfunction

   assign w_head_rd = r_fifo[r_head];
   assign w_pop     = mem_resp_valid && (r_count != '0);
   assign w_full    = (r_count == CNT_W'(MAX_PENDING));

   assign w_blk_rs1_a = f_blocked(id_rs1_a);
   assign w_blk_rs2_a = f_blocked(id_rs2_a);
   assign w_blk_rd_a  = f_blocked(id_rd_a);
   assign w_blk_rs1_b = f_blocked(id_rs1_b);
   assign w_blk_rs2_b = f_blocked(id_rs2_b);
   assign w_blk_rd_b  = f_blocked(id_rd_b);

   assign w_can_a = id_valid_a && !issue_flush
                 && !(id_uses_rs1_a && w_blk_rs1_a)
                 && !(id_uses_rs2_a && w_blk_rs2_a)
                 && !(id_reg_write_a && w_blk_rd_a)
                 && !(id_mem_read_a && w_full);

   assign w_raw = id_reg_write_a && !f_is_r0(id_rd_a)
               && ((id_uses_rs1_b && (id_rs1_b == id_rd_a))
                || (id_uses_rs2_b && (id_rs2_b == id_rd_a)));
   assign w_waw = id_reg_write_a && id_reg_write_b && !f_is_r0(id_rd_a)
               && (id_rd_a == id_rd_b);
   assign w_mem_pair = (id_mem_read_a || id_mem_write_a)
                    && (id_mem_read_b || id_mem_write_b);

   assign w_can_b = w_can_a && id_valid_b
                 && !(id_uses_rs1_b && w_blk_rs1_b)
                 && !(id_uses_rs2_b && w_blk_rs2_b)
                 && !(id_reg_write_b && w_blk_rd_b)
                 && !w_raw && !w_waw && !w_mem_pair
                 && !(id_mem_read_b && w_full);

   assign issue_a = rst_n && w_can_a;
   assign issue_b = rst_n && w_can_b;
   assign stall_a = rst_n && id_valid_a && !w_can_a && !issue_flush;
   assign b_hold  = rst_n && id_valid_b && !w_can_b && !issue_flush;

   // The memory-pair rule guarantees at most one load push per cycle.
   assign w_push_a  = w_can_a && id_mem_read_a;
   assign w_push_b  = w_can_b && id_mem_read_b;
   assign w_push    = w_push_a || w_push_b;
   assign w_push_rd = w_push_a ? id_rd_a : id_rd_b;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
         assign w_set[gi] = w_push && !f_is_r0(w_push_rd) && (f_idx(w_push_rd) == IDX_W'(gi));
         assign w_clr[gi] = w_pop && (f_idx(w_head_rd) == IDX_W'(gi));

         // Set has priority so a re-issued load keeps its register pending.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_pending[gi] <= 1'b0;
            else if (w_set[gi]) r_pending[gi] <= 1'b1;
            else if (w_clr[gi]) r_pending[gi] <= 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_PENDING; i++) r_fifo[i] <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_resp_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_tail] <= w_push_rd;
            r_tail         <= f_next(r_tail);
         end
         if (w_pop) r_head <= f_next(r_head);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (mem_resp_valid && (r_count == '0)) r_resp_err <= 1'b1;
      end
   end

   assign resp_rd       = w_head_rd;
   assign pending_count = r_count;
   assign fifo_full     = w_full;
   assign resp_err      = r_resp_err;

endmodule

// File: tb/tb_ternary_issue_scoreboard.sv
// Scenario bench for ternary_issue_scoreboard: load results are queued when a
// load issues and compared against resp_rd when its response is driven.
module tb_ternary_issue_scoreboard;
   import ternary_issue_scoreboard_pkg::*;

   localparam int K_NOP = 0;
   localparam int K_ALU = 1;
   localparam int K_LD  = 2;
   localparam int K_ST  = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid_a, id_valid_b;
   trit_t [2:0] id_rs1_a, id_rs2_a, id_rd_a, id_rs1_b, id_rs2_b, id_rd_b;
   logic        id_uses_rs1_a, id_uses_rs2_a, id_uses_rs1_b, id_uses_rs2_b;
   logic        id_reg_write_a, id_reg_write_b;
   logic        id_mem_read_a, id_mem_read_b, id_mem_write_a, id_mem_write_b;
   logic        issue_flush, mem_resp_valid;
   logic        issue_a, issue_b, stall_a, b_hold, fifo_full, resp_err;
   trit_t [2:0] resp_rd;
   logic [2:0]  pending_count;

   int checks = 0;
   int failures = 0;
   logic [5:0] exp_q[$];
   logic [5:0] exp_rd;

   always #5 clk = ~clk;

   ternary_issue_scoreboard dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid_a(id_valid_a), .id_valid_b(id_valid_b),
      .id_rs1_a(id_rs1_a), .id_rs2_a(id_rs2_a), .id_rd_a(id_rd_a),
      .id_rs1_b(id_rs1_b), .id_rs2_b(id_rs2_b), .id_rd_b(id_rd_b),
      .id_uses_rs1_a(id_uses_rs1_a), .id_uses_rs2_a(id_uses_rs2_a),
      .id_uses_rs1_b(id_uses_rs1_b), .id_uses_rs2_b(id_uses_rs2_b),
      .id_reg_write_a(id_reg_write_a), .id_reg_write_b(id_reg_write_b),
      .id_mem_read_a(id_mem_read_a), .id_mem_read_b(id_mem_read_b),
      .id_mem_write_a(id_mem_write_a), .id_mem_write_b(id_mem_write_b),
      .issue_flush(issue_flush), .mem_resp_valid(mem_resp_valid),
      .issue_a(issue_a), .issue_b(issue_b), .stall_a(stall_a), .b_hold(b_hold),
      .resp_rd(resp_rd), .pending_count(pending_count),
      .fifo_full(fifo_full), .resp_err(resp_err)
   );

   // Balanced-ternary encoding of a register value in -13..+13.
   function automatic logic [5:0] enc(input int v);
      logic [5:0] r;
      int rem;
      r = '0;
      for (int i = 0; i < 3; i++) begin
         rem = ((v % 3) + 3) % 3;
         if (rem == 1) begin r[2*i +: 2] = T_POS; v = (v - 1) / 3; end
         else if (rem == 2) begin r[2*i +: 2] = T_NEG; v = (v + 1) / 3; end
         else begin r[2*i +: 2] = T_ZERO; v = v / 3; end
      end
      return r;
   endfunction

   task automatic slot_a(input int kind, input int rs1, input int rs2, input int rd);
      id_valid_a     = (kind != K_NOP);
      id_rs1_a       = enc(rs1);
      id_rs2_a       = enc(rs2);
      id_rd_a        = enc(rd);
      id_uses_rs1_a  = (kind != K_NOP);
      id_uses_rs2_a  = (kind == K_ALU) || (kind == K_ST);
      id_reg_write_a = (kind == K_ALU) || (kind == K_LD);
      id_mem_read_a  = (kind == K_LD);
      id_mem_write_a = (kind == K_ST);
   endtask

   task automatic slot_b(input int kind, input int rs1, input int rs2, input int rd);
      id_valid_b     = (kind != K_NOP);
      id_rs1_b       = enc(rs1);
      id_rs2_b       = enc(rs2);
      id_rd_b        = enc(rd);
      id_uses_rs1_b  = (kind != K_NOP);
      id_uses_rs2_b  = (kind == K_ALU) || (kind == K_ST);
      id_reg_write_b = (kind == K_ALU) || (kind == K_LD);
      id_mem_read_b  = (kind == K_LD);
      id_mem_write_b = (kind == K_ST);
   endtask

   task automatic idle();
      slot_a(K_NOP, 0, 0, 0);
      slot_b(K_NOP, 0, 0, 0);
      issue_flush    = 1'b0;
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      slot_a(K_ALU, 1, 2, 3);
      #1;
      checks++; if (issue_a !== 1'b0) begin failures++; $display("FAIL rst_issue_a got=%b exp=0", issue_a); end
      checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL rst_stall_a got=%b exp=0", stall_a); end
      checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", pending_count); end
      checks++; if (resp_rd !== 6'd0) begin failures++; $display("FAIL rst_resp_rd got=%h exp=0", resp_rd); end
      checks++; if (resp_err !== 1'b0 || fifo_full !== 1'b0) begin failures++; $display("FAIL rst_flags got err=%b full=%b exp=0,0", resp_err, fifo_full); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle();
      $display("reset released");
   endtask

   task automatic test_load_use();
      @(negedge clk); idle(); slot_a(K_LD, 0, 0, 5); #1;
      checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL lu_load_issue got=%b exp=1", issue_a); end
      exp_q.push_back(enc(5));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); slot_a(K_ALU, 5, 2, 3); #1;
         checks++; if (pending_count !== 3'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", pending_count); end
         checks++; if (resp_rd !== enc(5)) begin failures++; $display("FAIL lu_resp_rd got=%h exp=%h", resp_rd, enc(5)); end
         checks++; if (stall_a !== 1'b1 || issue_a !== 1'b0) begin failures++; $display("FAIL lu_stall got stall=%b issue=%b exp=1,0", stall_a, issue_a); end
      end
      @(negedge clk); mem_resp_valid = 1'b1; #1;
      checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL lu_bypass got=%b exp=1", issue_a); end
      exp_rd = exp_q.pop_front();
      checks++; if (resp_rd !== exp_rd) begin failures++; $display("FAIL lu_pop got=%h exp=%h", resp_rd, exp_rd); end
      @(negedge clk); idle(); #1;
      checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL lu_drain got=%0d exp=0", pending_count); end
      $display("load-use scenario done");
   endtask

   task automatic test_pairing();
      @(negedge clk); idle(); slot_a(K_ALU, 1, 2, 3); slot_b(K_ALU, 3, 2, 9); #1;
      checks++; if ({issue_a, issue_b, b_hold} !== 3'b101) begin failures++; $display("FAIL pair_raw got a/b/hold=%b exp=101", {issue_a, issue_b, b_hold}); end
      slot_b(K_ALU, 4, 2, 9); #1;
      checks++; if ({issue_a, issue_b, b_hold} !== 3'b110) begin failures++; $display("FAIL pair_indep got a/b/hold=%b exp=110", {issue_a, issue_b, b_hold}); end
      slot_b(K_ALU, 4, 4, 3); #1;
      checks++; if ({issue_b, b_hold} !== 2'b01) begin failures++; $display("FAIL pair_waw got b/hold=%b exp=01", {issue_b, b_hold}); end
      slot_a(K_NOP, 0, 0, 0); slot_b(K_ALU, 4, 2, 9); #1;
      checks++; if ({issue_b, b_hold} !== 2'b01) begin failures++; $display("FAIL pair_b_alone got b/hold=%b exp=01", {issue_b, b_hold}); end
      $display("pairing scenario done");
   endtask

   task automatic test_fifo_full();
      int rds[4];
      rds = '{1, 2, 4, 6};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); idle(); slot_a(K_LD, 0, 0, rds[i]); #1;
         checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL ff_load%0d got=%b exp=1", i, issue_a); end
         exp_q.push_back(enc(rds[i]));
      end
      @(negedge clk); slot_a(K_LD, 0, 0, 9); #1;
      checks++; if (fifo_full !== 1'b1 || pending_count !== 3'd4) begin failures++; $display("FAIL ff_full got full=%b cnt=%0d exp=1,4", fifo_full, pending_count); end
      checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL ff_fifth_stall got=%b exp=1", stall_a); end
      @(negedge clk); slot_a(K_ALU, 7, 7, 7); #1;
      checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL ff_alu_issue got=%b exp=1", issue_a); end
      @(negedge clk); slot_a(K_LD, 0, 0, 9); mem_resp_valid = 1'b1; #1;
      checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL ff_no_credit got=%b exp=1", stall_a); end
      exp_rd = exp_q.pop_front();
      checks++; if (resp_rd !== exp_rd) begin failures++; $display("FAIL ff_pop0 got=%h exp=%h", resp_rd, exp_rd); end
      @(negedge clk); mem_resp_valid = 1'b0; #1;
      checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL ff_fifth_issue got=%b exp=1", issue_a); end
      exp_q.push_back(enc(9));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); idle(); mem_resp_valid = 1'b1; #1;
         exp_rd = exp_q.pop_front();
         checks++; if (resp_rd !== exp_rd) begin failures++; $display("FAIL ff_pop%0d got=%h exp=%h", i + 1, resp_rd, exp_rd); end
      end
      @(negedge clk); idle(); #1;
      checks++; if (pending_count !== 3'd0 || resp_err !== 1'b0) begin failures++; $display("FAIL ff_drain got cnt=%0d err=%b exp=0,0", pending_count, resp_err); end
      $display("fifo-full scenario done");
   endtask

   task automatic test_mem_conflict();
      @(negedge clk); idle(); slot_a(K_LD, 0, 0, 10); slot_b(K_ST, 11, 12, 0); #1;
      checks++; if ({issue_a, issue_b} !== 2'b10) begin failures++; $display("FAIL mc_ld_st got a/b=%b exp=10", {issue_a, issue_b}); end
      exp_q.push_back(enc(10));
      @(negedge clk); idle(); slot_a(K_LD, 0, 0, 0); #1;
      checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL mc_ld_r0 got=%b exp=1", issue_a); end
      exp_q.push_back(enc(0));
      @(negedge clk); idle(); slot_a(K_ALU, 0, 0, 13); slot_b(K_ALU, 0, 0, 12); #1;
      checks++; if (pending_count !== 3'd2) begin failures++; $display("FAIL mc_count got=%0d exp=2", pending_count); end
      checks++; if ({issue_a, issue_b} !== 2'b11) begin failures++; $display("FAIL mc_r0_reader got a/b=%b exp=11", {issue_a, issue_b}); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); idle(); mem_resp_valid = 1'b1; #1;
         exp_rd = exp_q.pop_front();
         checks++; if (resp_rd !== exp_rd) begin failures++; $display("FAIL mc_pop%0d got=%h exp=%h", i, resp_rd, exp_rd); end
      end
      @(negedge clk); idle(); #1;
      checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL mc_drain got=%0d exp=0", pending_count); end
      $display("memory-conflict scenario done");
   endtask

   task automatic test_flush();
      @(negedge clk); idle(); slot_a(K_LD, 0, 0, 11); #1;
      exp_q.push_back(enc(11));
      @(negedge clk); idle(); issue_flush = 1'b1; mem_resp_valid = 1'b1;
      slot_a(K_ALU, 11, 1, 2); slot_b(K_ALU, 1, 1, 3); #1;
      checks++; if ({issue_a, issue_b, stall_a, b_hold} !== 4'b0000) begin failures++; $display("FAIL fl_outputs got=%b exp=0000", {issue_a, issue_b, stall_a, b_hold}); end
      exp_rd = exp_q.pop_front();
      checks++; if (resp_rd !== exp_rd) begin failures++; $display("FAIL fl_pop got=%h exp=%h", resp_rd, exp_rd); end
      @(negedge clk); idle(); #1;
      checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL fl_drain got=%0d exp=0", pending_count); end
      $display("flush scenario done");
   endtask

   task automatic test_back_to_back();
      @(negedge clk); idle(); slot_a(K_LD, 0, 0, 8); #1;
      exp_q.push_back(enc(8));
      @(negedge clk); slot_a(K_LD, 0, 0, 8); mem_resp_valid = 1'b1; #1;
      checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL bb_reissue got=%b exp=1", issue_a); end
      exp_rd = exp_q.pop_front();
      checks++; if (resp_rd !== exp_rd) begin failures++; $display("FAIL bb_pop got=%h exp=%h", resp_rd, exp_rd); end
      exp_q.push_back(enc(8));
      @(negedge clk); idle(); slot_a(K_ALU, 8, 1, 2); #1;
      checks++; if (pending_count !== 3'd1) begin failures++; $display("FAIL bb_count got=%0d exp=1", pending_count); end
      checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL bb_still_pending got=%b exp=1", stall_a); end
      @(negedge clk); mem_resp_valid = 1'b1; #1;
      checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL bb_final_bypass got=%b exp=1", issue_a); end
      exp_rd = exp_q.pop_front();
      checks++; if (resp_rd !== exp_rd) begin failures++; $display("FAIL bb_pop2 got=%h exp=%h", resp_rd, exp_rd); end
      @(negedge clk); idle(); #1;
      checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL bb_drain got=%0d exp=0", pending_count); end
      $display("back-to-back scenario done");
   endtask

   task automatic test_resp_err_async_reset();
      int rds[3];
      rds = '{1, 2, 4};
      @(negedge clk); idle(); mem_resp_valid = 1'b1;
      @(negedge clk); idle(); #1;
      checks++; if (resp_err !== 1'b1 || pending_count !== 3'd0) begin failures++; $display("FAIL re_sticky got err=%b cnt=%0d exp=1,0", resp_err, pending_count); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle(); slot_a(K_LD, 0, 0, rds[i]); #1;
         exp_q.push_back(enc(rds[i]));
      end
      @(negedge clk); idle(); slot_a(K_ALU, 1, 2, 3); #1;
      checks++; if (pending_count !== 3'd3 || stall_a !== 1'b1) begin failures++; $display("FAIL re_pre_reset got cnt=%0d stall=%b exp=3,1", pending_count, stall_a); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL re_async_count got=%0d exp=0", pending_count); end
      checks++; if ({issue_a, stall_a, resp_err} !== 3'b000) begin failures++; $display("FAIL re_async_out got issue/stall/err=%b exp=000", {issue_a, stall_a, resp_err}); end
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1; #1;
      checks++; if (issue_a !== 1'b1) begin failures++; $display("FAIL re_mask_cleared got=%b exp=1", issue_a); end
      $display("resp_err / async reset scenario done");
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_pairing();
      test_fifo_full();
      test_mem_conflict();
      test_flush();
      test_back_to_back();
      test_resp_err_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end
endmodule
